// File: rtl/gb_audio_mixer_if.sv
// Channel-level inputs and mixed/sampled/PDM outputs of the APU audio mixer.
// The master side is the channel source; the slave side is the mixer.
interface gb_audio_mixer_if;
  logic       apu_enable;
  logic [3:0] level1, level2, level3, level4;
  logic       enable1, enable2, enable3, enable4;
  logic [7:0] panning;
  logic [7:0] master_volume;
  logic [8:0] mix_left, mix_right;
  logic [8:0] sample_left, sample_right;
  logic       sample_valid;
  logic       pdm_left, pdm_right;

  modport master (
    output apu_enable, level1, level2, level3, level4,
           enable1, enable2, enable3, enable4, panning, master_volume,
    input  mix_left, mix_right, sample_left, sample_right, sample_valid,
           pdm_left, pdm_right
  );

  modport slave (
    input  apu_enable, level1, level2, level3, level4,
           enable1, enable2, enable3, enable4, panning, master_volume,
    output mix_left, mix_right, sample_left, sample_right, sample_valid,
           pdm_left, pdm_right
  );
endinterface

// File: rtl/gb_audio_mixer.sv
// Game Boy audio mixer: NR51 panning, NR50 volume, 2-stage mix pipeline,
// decimated sample strobe and first-order sigma-delta PDM per output side.
module gb_mix_side (
  input  logic            clk,
  input  logic            reset,
  input  logic            apu_en,
  input  logic [3:0][3:0] eff,
  input  logic [3:0]      pan,
  input  logic [2:0]      vol,
  output logic [8:0]      mix,
  output logic            pdm
);
  logic [5:0] sum_d, sum_q;
  logic [2:0] vol_d, vol_q;
  logic [8:0] mix_d, mix_q;
  logic [9:0] acc_d, acc_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < 4; i++)
      if (pan[i]) sum_d = sum_d + {2'b00, eff[i]};
    // volume travels with the sum so both reach the multiplier from the same input edge
    vol_d = vol;
    mix_d = {3'b000, sum_q}
          + (vol_q[0] ? {3'b000, sum_q}       : 9'd0)
          + (vol_q[1] ? {2'b00, sum_q, 1'b0}  : 9'd0)
          + (vol_q[2] ? {1'b0, sum_q, 2'b00}  : 9'd0);
    acc_d = {1'b0, acc_q[8:0]} + {1'b0, mix_q};
    if (!apu_en) begin
      sum_d = '0;
      vol_d = '0;
      mix_d = '0;
      acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_q <= '0;
      vol_q <= '0;
      mix_q <= '0;
      acc_q <= '0;
    end else begin
      sum_q <= sum_d;
      vol_q <= vol_d;
      mix_q <= mix_d;
      acc_q <= acc_d;
    end
  end

  assign mix = mix_q;
  // carry out of the 9-bit residue, already a register bit
  assign pdm = acc_q[9];
endmodule

module gb_audio_mixer #(
  parameter int unsigned SAMPLE_DIV = 64
) (
  input logic             clk,
  input logic             reset,
  gb_audio_mixer_if.slave bus
);
  localparam int SIDES = 2;
  localparam logic [15:0] CNT_MAX = 16'(SAMPLE_DIV - 1);

  logic [3:0][3:0]       eff;
  logic [SIDES-1:0][3:0] pan;
  logic [SIDES-1:0][2:0] vol;
  logic [SIDES-1:0][8:0] mix;
  logic [SIDES-1:0]      pdm;
  logic                  unused_vin;

  assign eff[0] = bus.enable1 ? bus.level1 : 4'd0;
  assign eff[1] = bus.enable2 ? bus.level2 : 4'd0;
  assign eff[2] = bus.enable3 ? bus.level3 : 4'd0;
  assign eff[3] = bus.enable4 ? bus.level4 : 4'd0;
  // side 0 = left, side 1 = right
  assign pan[0] = bus.panning[7:4];
  assign pan[1] = bus.panning[3:0];
  assign vol[0] = bus.master_volume[6:4];
  assign vol[1] = bus.master_volume[2:0];
  assign unused_vin = bus.master_volume[7] ^ bus.master_volume[3];

  generate
    for (genvar s = 0; s < SIDES; s++) begin : g_side
      gb_mix_side u_side (
        .clk    (clk),
        .reset  (reset),
        .apu_en (bus.apu_enable),
        .eff    (eff),
        .pan    (pan[s]),
        .vol    (vol[s]),
        .mix    (mix[s]),
        .pdm    (pdm[s])
      );
    end
  endgenerate

  logic [15:0]           cnt_d, cnt_q;
  logic [SIDES-1:0][8:0] smp_d, smp_q;
  logic                  valid_d, valid_q;

  always_comb begin
    cnt_d   = cnt_q + 16'd1;
    smp_d   = smp_q;
    valid_d = 1'b0;
    if (!bus.apu_enable) begin
      cnt_d = '0;
      smp_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      smp_d   = mix;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      smp_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      smp_q   <= smp_d;
      valid_q <= valid_d;
    end
  end

  assign bus.mix_left     = mix[0];
  assign bus.mix_right    = mix[1];
  assign bus.pdm_left     = pdm[0];
  assign bus.pdm_right    = pdm[1];
  assign bus.sample_left  = smp_q[0];
  assign bus.sample_right = smp_q[1];
  assign bus.sample_valid = valid_q;
endmodule

// File: doc/gb_audio_mixer.md
# gb_audio_mixer

Downstream consumer of the four channel generators (pulse 1/2, wave, noise). Takes each channel's 4-bit `level` and `enable`, applies NR51 panning and NR50 master volume, and produces registered 9-bit left/right mix values. It also produces a periodic decimated sample pair with a valid strobe, and a first-order sigma-delta 1-bit PDM stream per side for an external RC/pin DAC.

## Interface
Parameters:
- `SAMPLE_DIV`, 64: clk cycles per `sample_valid` strobe; legal range 2..65535.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-low reset.
- `apu_enable`  in  1  NR52 bit 7 master power.
- `level1`..`level4`  in  4 each  channel outputs, unsigned 0..15.
- `enable1`..`enable4`  in  1 each  channel active; when low, that channel contributes 0.
- `panning`  in  8  NR51 value:
  - bits 7:4 route ch4..ch1 to left.
  - bits 3:0 route ch4..ch1 to right.
- `master_volume`  in  8  NR50 value:
  - bits 6:4 = left volume VL.
  - bits 2:0 = right volume VR.
  - bits 7 and 3 (VIN) ignored.
- `mix_left`, `mix_right`  out  9  continuous mixed value, 0..480.
- `sample_left`, `sample_right`  out  9  decimated sample, held between strobes.
- `sample_valid`  out  1  one-cycle pulse when the sample outputs update.
- `pdm_left`, `pdm_right`  out  1  sigma-delta bitstreams.

## Operation
- Effective channel value: `eff_n = enable_n ? level_n : 0`.
- Stage 1 (registered):
  - `sum_l` = Σ of `eff_n` where the left pan bit for channel n is set.
  - `sum_r` likewise with the right pan bits.
  - Width 6 bits; maximum 60; no overflow possible.
- Stage 2 (registered): `mix_left = sum_l * (VL+1)`, `mix_right = sum_r * (VR+1)`.
  - 9-bit result; maximum 60*8 = 480.
  - Multiply is by a 1..8 constant and may be implemented as shift-add.
- Sample decimator:
  - Counter `cnt` runs 0..SAMPLE_DIV-1 and wraps.
  - When `cnt == SAMPLE_DIV-1`, on the next edge: `sample_left/right` latch the current `mix_left/right`, `sample_valid` = 1 for exactly one cycle, and `cnt` returns to 0.
- Sigma-delta, per side:
  - 10-bit accumulator `acc`; each cycle `acc <= {1'b0, acc[8:0]} + mix`.
  - `pdm = acc[9]` (registered).
  - Ones density over any 512 consecutive cycles with constant input = `mix/512` exactly, once settled.
- `apu_enable` low:
  - Stage registers, mix outputs, accumulators, PDM outputs and sample outputs are forced to 0 on the next edge.
  - `cnt` is held at 0; `sample_valid` = 0.
  - `apu_enable` rising: `cnt` counts from 0, so the first `sample_valid` comes SAMPLE_DIV cycles later. Pipeline refills normally.
- Panning, volume, level and enable changes are sampled every cycle. There is no glitch filtering; changes appear at the outputs with the latency below.

## Timing
- Reset (`reset` low at a posedge): every output register and internal register is 0. This covers `mix_*`, `sample_*`, `sample_valid`, `pdm_*`, `acc`, `cnt` and the stage-1 sums. Reset mid-operation discards in-flight pipeline data.
- Inputs sampled at edge N appear in stage 1 after N, and on `mix_*` after edge N+1 (2-cycle latency).
- The `mix_*` value present after edge M is added into `acc` at edge M+1, and `pdm_*` reflects that carry after edge M+1.
- `sample_*` equals the `mix_*` value visible during the cycle in which `cnt == SAMPLE_DIV-1`.
- First `sample_valid` after reset release occurs on the SAMPLE_DIV-th edge with `reset` high and `apu_enable` high.
- Simultaneous `reset` low and `apu_enable` low: reset dominates; the result is identical (all zero).
- `apu_enable` falling while `cnt == SAMPLE_DIV-1`: no strobe is produced and samples clear to 0.

## Test plan
- Single channel, both sides:
  - Stimulus: `level1=15`, `enable1=1`, others disabled, `panning=8'h11`, `master_volume=8'h77`.
  - Response: `mix_left = mix_right = 120` exactly 2 cycles after the inputs are applied.
- Full scale with asymmetric volume:
  - Stimulus: all levels 15, all enabled, `panning=8'hFF`, `master_volume=8'h70`.
  - Response: `mix_left=480`, `mix_right=60`.
- Panning and enable masking:
  - Stimulus: levels 1, 2, 4, 8; `panning=8'hA5`; `enable3=0`; `master_volume=8'h00`.
  - Response: left = ch4+ch2 = 10; right = ch1 only = 1 (ch3 masked).
- Decimation, with `SAMPLE_DIV=64`:
  - `sample_valid` pulses exactly every 64 cycles and is never two cycles wide.
  - Stepping `mix` from 0 to 120 mid-window: the next sample is 120 and the previous sample is held until then.
- PDM density: constant `mix_left=256` held for 1024 cycles after settling yields exactly 512 ones on `pdm_left`; `mix_left=0` yields 0 ones.
- Power/reset:
  - Dropping `apu_enable` mid-run: all outputs read 0 on the next edge.
  - Re-enabling: first strobe comes 64 cycles later.
  - Asserting `reset` with nonzero state: all outputs read 0 after one edge.
